// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation encodings, FSM states and widths.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add unsigned multiplier; one multiplier bit is consumed per step.
module alu_mc_mul #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_step,
    input  logic [DATA_WIDTH-1:0]   i_mcand,
    input  logic [DATA_WIDTH-1:0]   i_mplier,
    output logic                    o_done,
    output logic [2*DATA_WIDTH-1:0] o_product
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*DATA_WIDTH-1:0] acc_next;

    // Accumulator value including the current step's partial product.
    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign o_done    = i_step && (cnt_q == '0);
    assign o_product = acc_next;

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (i_start) begin
            cnt_d    = CNT_INIT;
            acc_d    = '0;
            mcand_d  = {{DATA_WIDTH{1'b0}}, i_mcand};
            mplier_d = i_mplier;
        end else if (i_step) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle ops register at accept, MUL runs DATA_WIDTH steps.
// Valid/ready: a transfer happens on a rising edge where valid && ready; data holds while valid && !ready.
module alu_mc
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_elemA,
    input  logic [DATA_WIDTH-1:0] i_elemB,
    input  alu_op_e               i_op,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_output,
    output logic                  o_zero,
    output logic                  o_carry,
    output logic                  o_overflow,
    output alu_state_e            o_state
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int MSB     = DATA_WIDTH - 1;

    alu_state_e            state_q, state_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  zero_q, zero_d;
    logic                  carry_q, carry_d;
    logic                  ovf_q, ovf_d;

    logic                    accept;
    logic                    mul_start, mul_step, mul_done;
    logic [2*DATA_WIDTH-1:0] mul_product;

    logic [DATA_WIDTH:0]   sum_add, sum_sub;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_zero, alu_carry, alu_ovf, alu_zero_en;

    assign o_ready = (state_q == ST_IDLE) && (!valid_q || i_ready);
    assign accept  = i_valid && o_ready;

    always_comb begin
        sum_add     = {1'b0, i_elemA} + {1'b0, i_elemB};
        sum_sub     = {1'b0, i_elemA} + {1'b0, ~i_elemB} + (DATA_WIDTH + 1)'(1);
        shamt       = i_elemB[SHAMT_W-1:0];
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_ovf     = 1'b0;
        alu_zero_en = 1'b1;
        case (i_op)
            OP_ADD: begin
                alu_res   = sum_add[DATA_WIDTH-1:0];
                alu_carry = sum_add[DATA_WIDTH];
                alu_ovf   = (i_elemA[MSB] == i_elemB[MSB]) && (alu_res[MSB] != i_elemA[MSB]);
            end
            OP_SUB: begin
                alu_res   = sum_sub[DATA_WIDTH-1:0];
                alu_carry = sum_sub[DATA_WIDTH];
                alu_ovf   = (i_elemA[MSB] != i_elemB[MSB]) && (alu_res[MSB] != i_elemA[MSB]);
            end
            OP_AND:  alu_res = i_elemA & i_elemB;
            OP_OR:   alu_res = i_elemA | i_elemB;
            OP_XOR:  alu_res = i_elemA ^ i_elemB;
            OP_SLL:  alu_res = i_elemA << shamt;
            OP_SRL:  alu_res = i_elemA >> shamt;
            OP_SRA:  alu_res = $signed(i_elemA) >>> shamt;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_elemA) < $signed(i_elemB))};
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (i_elemA < i_elemB)};
            // MUL never loads through this path; unused encodings report all flags clear.
            default: alu_zero_en = 1'b0;
        endcase
        alu_zero = alu_zero_en && (alu_res == '0);
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        res_d     = res_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (i_op == OP_MUL) begin
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        res_d   = alu_res;
                        zero_d  = alu_zero;
                        carry_d = alu_carry;
                        ovf_d   = alu_ovf;
                    end
                end
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_done) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
                    res_d   = mul_product[DATA_WIDTH-1:0];
                    zero_d  = (mul_product[DATA_WIDTH-1:0] == '0);
                    carry_d = 1'b0;
                    ovf_d   = (mul_product[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    alu_mc_mul #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mul (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (mul_start),
        .i_step    (mul_step),
        .i_mcand   (i_elemA),
        .i_mplier  (i_elemB),
        .o_done    (mul_done),
        .o_product (mul_product)
    );

    assign o_valid    = valid_q;
    assign o_output   = res_q;
    assign o_zero     = zero_q;
    assign o_carry    = carry_q;
    assign o_overflow = ovf_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at DATA_WIDTH=8 with hand-computed expectations.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] elem_a;
    logic [W-1:0] elem_b;
    alu_op_e      op;
    logic         out_valid;
    logic         in_ready;
    logic [W-1:0] result;
    logic         zero_f;
    logic         carry_f;
    logic         ovf_f;
    alu_state_e   state;

    int checks   = 0;
    int failures = 0;

    // Expected result word: {valid, output, zero, carry, overflow}
    logic [W+3:0] got;
    logic [W+3:0] exp_v;
    logic [W-1:0] exp_q[$];

    alu_mc #(.DATA_WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (in_valid),
        .o_ready    (out_ready),
        .i_elemA    (elem_a),
        .i_elemB    (elem_b),
        .i_op       (op),
        .o_valid    (out_valid),
        .i_ready    (in_ready),
        .o_output   (result),
        .o_zero     (zero_f),
        .o_carry    (carry_f),
        .o_overflow (ovf_f),
        .o_state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got = {out_valid, result, zero_f, carry_f, ovf_f};

    // Inputs change 1ns after a rising edge and outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input alu_op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
        op       = o;
        elem_a   = a;
        elem_b   = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        in_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({got, out_ready, state} !== {1'b0, 8'h00, 3'b000, 1'b1, ST_IDLE}) begin
            failures++;
            $display("FAIL reset: got=%h ready=%b state=%0d want valid/out/flags=0 ready=1 idle",
                     got, out_ready, state);
        end
    endtask

    task automatic test_add_sub();
        in_ready = 1'b1;
        drive_op(OP_ADD, 8'h7F, 8'h01);
        exp_v = {1'b1, 8'h80, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL add_ovf: got=%h want=%h", got, exp_v);
        end
        drive_op(OP_SUB, 8'h05, 8'h05);
        exp_v = {1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL sub_zero: got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_shift_slt();
        alu_op_e      ops[7];
        logic [W-1:0] as[7];
        logic [W-1:0] bs[7];
        logic [W+3:0] want[7];
        ops[0] = OP_SRA;  as[0] = 8'h90; bs[0] = 8'h03; want[0] = {1'b1, 8'hF2, 3'b000};
        ops[1] = OP_SRL;  as[1] = 8'h90; bs[1] = 8'h03; want[1] = {1'b1, 8'h12, 3'b000};
        ops[2] = OP_SLT;  as[2] = 8'hFF; bs[2] = 8'h01; want[2] = {1'b1, 8'h01, 3'b000};
        ops[3] = OP_SLTU; as[3] = 8'hFF; bs[3] = 8'h01; want[3] = {1'b1, 8'h00, 3'b100};
        ops[4] = OP_SRA;  as[4] = 8'h90; bs[4] = 8'h08; want[4] = {1'b1, 8'h90, 3'b000};
        ops[5] = OP_SLL;  as[5] = 8'h81; bs[5] = 8'h01; want[5] = {1'b1, 8'h02, 3'b000};
        ops[6] = alu_op_e'(4'd12); as[6] = 8'h05; bs[6] = 8'h05; want[6] = {1'b1, 8'h00, 3'b000};
        in_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_op(ops[i], as[i], bs[i]);
            checks++;
            if (got !== want[i]) begin
                failures++;
                $display("FAIL shift_slt[%0d]: got=%h want=%h", i, got, want[i]);
            end
        end
    endtask

    task automatic test_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W+3:0] want);
        int early_bad;
        in_ready  = 1'b1;
        early_bad = 0;
        drive_op(OP_MUL, a, b);
        for (int k = 1; k <= W; k++) begin
            if (out_ready !== 1'b0 || out_valid !== 1'b0 || state !== ST_MUL) begin
                early_bad++;
            end
            tick();
        end
        checks++;
        if (early_bad != 0) begin
            failures++;
            $display("FAIL mul_busy %h*%h: %0d busy cycles with ready/valid high or not in MUL, want 0",
                     a, b, early_bad);
        end
        checks++;
        if ({got, state} !== {want, ST_IDLE}) begin
            failures++;
            $display("FAIL mul_result %h*%h: got=%h state=%0d want=%h idle", a, b, got, state, want);
        end
    endtask

    task automatic test_backpressure();
        int hold_bad;
        drain();
        in_ready = 1'b0;
        drive_op(OP_ADD, 8'hF0, 8'h20);
        exp_v = {1'b1, 8'h10, 1'b0, 1'b1, 1'b0};
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL bp_load: got=%h want=%h", got, exp_v);
        end
        op       = OP_SUB;
        elem_a   = 8'h09;
        elem_b   = 8'h04;
        in_valid = 1'b1;
        hold_bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (got !== exp_v || out_ready !== 1'b0) begin
                hold_bad++;
            end
        end
        checks++;
        if (hold_bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d stalled cycles changed output or had ready high, want 0", hold_bad);
        end
        in_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_v = {1'b1, 8'h05, 1'b0, 1'b1, 1'b0};
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL bp_same_edge: got=%h want=%h", got, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        alu_op_e      ops[5];
        logic [W-1:0] as[5];
        logic [W-1:0] bs[5];
        logic [W-1:0] want;
        ops[0] = OP_ADD; as[0] = 8'h11; bs[0] = 8'h22; exp_q.push_back(8'h33);
        ops[1] = OP_SUB; as[1] = 8'h10; bs[1] = 8'h20; exp_q.push_back(8'hF0);
        ops[2] = OP_AND; as[2] = 8'hF0; bs[2] = 8'h3C; exp_q.push_back(8'h30);
        ops[3] = OP_OR;  as[3] = 8'h0F; bs[3] = 8'h30; exp_q.push_back(8'h3F);
        ops[4] = OP_XOR; as[4] = 8'hFF; bs[4] = 8'h0F; exp_q.push_back(8'h0F ^ 8'hFF);
        in_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op     = ops[i];
            elem_a = as[i];
            elem_b = bs[i];
            tick();
            want = exp_q.pop_front();
            checks++;
            if ({out_valid, result} !== {1'b1, want}) begin
                failures++;
                $display("FAIL b2b[%0d]: valid=%b out=%h want valid=1 out=%h", i, out_valid, result, want);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int stray;
        drain();
        drive_op(OP_MUL, 8'h13, 8'h0D);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({out_valid, result, zero_f, carry_f, ovf_f, out_ready, state} !==
            {1'b0, 8'h00, 3'b000, 1'b1, ST_IDLE}) begin
            failures++;
            $display("FAIL rst_mid_mul: got=%h ready=%b state=%0d want 0s ready=1 idle",
                     got, out_ready, state);
        end
        stray = 0;
        for (int k = 0; k < W + 2; k++) begin
            tick();
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL rst_discard: %0d cycles with valid after reset, want 0", stray);
        end
        drive_op(OP_ADD, 8'h02, 8'h03);
        exp_v = {1'b1, 8'h05, 3'b000};
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL rst_then_add: got=%h want=%h", got, exp_v);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b1;
        elem_a   = '0;
        elem_b   = '0;
        op       = OP_ADD;
        #1;
        test_reset();
        test_add_sub();
        test_shift_slt();
        test_mul(8'h13, 8'h0D, {1'b1, 8'hF7, 3'b000});
        test_mul(8'h10, 8'h10, {1'b1, 8'h00, 3'b101});
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
